// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: display reads take priority over host reads/writes
// with a starvation bound, and read returns are routed through an in-order tag FIFO.
module vram_arbiter #(
  parameter int AWIDTH     = 19,
  parameter int PWIDTH     = 8,
  parameter int TAGDEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_core,
  input  logic              rst_core_n,
  input  logic              d_rd,
  input  logic [AWIDTH-1:0] d_addr,
  output logic              d_busy,
  output logic [PWIDTH-1:0] d_data,
  output logic              d_vld,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [AWIDTH-1:0] h_addr,
  input  logic [PWIDTH-1:0] h_wdata,
  output logic              h_ack,
  output logic [PWIDTH-1:0] h_rdata,
  output logic              h_rvld,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [PWIDTH-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [PWIDTH-1:0] mem_rdata,
  input  logic              mem_rvld,
  output logic              err_orphan
);

  localparam int PW = $clog2(TAGDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [TAGDEPTH-1:0] tags;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [SW-1:0]       starve;

  logic full, empty, pop, pop_tag, fifo_ok;
  logic d_elig, h_elig, d_win, h_win;
  logic xfer_d, xfer_h, push;

  always_comb begin
    full    = (count == CW'(TAGDEPTH));
    empty   = (count == '0);
    pop     = mem_rvld && !empty;
    pop_tag = tags[rd_ptr];
    // A full FIFO can still take a tag when a return frees a slot this cycle.
    fifo_ok = !full || mem_rvld;

    d_elig = rst_core_n && d_rd && fifo_ok;
    h_elig = rst_core_n && h_req && (h_we || fifo_ok);
    h_win  = h_elig && (!d_elig || (starve == SW'(STARVE_MAX)));
    d_win  = d_elig && !h_win;

    mem_req   = d_elig || h_elig;
    mem_we    = h_win && h_we;
    mem_addr  = h_win ? h_addr : d_addr;
    mem_wdata = h_win ? h_wdata : '0;

    xfer_d = d_win && mem_ready;
    xfer_h = h_win && mem_ready;
    push   = xfer_d || (xfer_h && !h_we);

    h_ack  = xfer_h;
    d_busy = !xfer_d;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      tags       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      err_orphan <= 1'b0;
      d_vld      <= 1'b0;
      h_rvld     <= 1'b0;
      d_data     <= '0;
      h_rdata    <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= xfer_h;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (!h_req || xfer_h)                                starve <= '0;
      else if (xfer_d && (starve != SW'(STARVE_MAX)))      starve <= starve + SW'(1);

      d_vld  <= pop && !pop_tag;
      h_rvld <= pop && pop_tag;
      if (pop && !pop_tag) d_data  <= mem_rdata;
      if (pop && pop_tag)  h_rdata <= mem_rdata;

      if (mem_rvld && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a table of single-cycle grant vectors
// followed by hand-written multi-cycle sequences for routing, FIFO and reset cases.
module tb_vram_arbiter;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        d_rd, h_req, h_we, mem_ready, man_rvld, auto_en;
  logic        auto_rvld = 1'b0;
  logic [18:0] d_addr, h_addr, mem_addr;
  logic [7:0]  h_wdata, mem_rdata, d_data, h_rdata, mem_wdata;
  logic        d_busy, d_vld, h_ack, h_rvld, mem_req, mem_we, mem_rvld, err_orphan;

  int tests = 0;
  int failed = 0;

  always #5 clk_core = ~clk_core;

  // Memory model for the contention run: every accepted read returns next cycle.
  always @(posedge clk_core) auto_rvld <= auto_en & mem_req & mem_ready & ~mem_we;
  assign mem_rvld = man_rvld | auto_rvld;

  vram_arbiter #(.AWIDTH(19), .PWIDTH(8), .TAGDEPTH(4), .STARVE_MAX(8)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .d_rd(d_rd), .d_addr(d_addr), .d_busy(d_busy), .d_data(d_data), .d_vld(d_vld),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata), .h_rvld(h_rvld),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvld(mem_rvld),
    .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic d_rd, h_req, h_we, rdy;
    logic [18:0] da, ha;
    logic [7:0]  hw;
    logic e_req, e_we, e_ack, e_busy, chk_bus;
    logic [18:0] e_addr;
    logic [7:0]  e_wd;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic dr, hr, hwe, rdy, input logic [18:0] da, ha,
                              input logic [7:0] hw, input logic er, ewe, eack, ebusy, cb,
                              input logic [18:0] ea, input logic [7:0] ewd);
    vec_t v;
    v = '{d_rd:dr, h_req:hr, h_we:hwe, rdy:rdy, da:da, ha:ha, hw:hw, e_req:er, e_we:ewe,
          e_ack:eack, e_busy:ebusy, chk_bus:cb, e_addr:ea, e_wd:ewd};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs;
    d_rd = 0; h_req = 0; h_we = 0; mem_ready = 1; man_rvld = 0; auto_en = 0;
    d_addr = '0; h_addr = '0; h_wdata = '0; mem_rdata = '0;
  endtask

  task automatic next_cycle;
    @(posedge clk_core); #1;
  endtask

  task automatic do_reset;
    rst_core_n = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_core_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(0,0,0,1, 19'h0,     19'h0,     8'h00, 0,0,0,1,0, 19'h0,     8'h00);
    vecs[1] = mk(1,0,0,0, 19'h123,   19'h0,     8'h00, 1,0,0,1,1, 19'h123,   8'h00);
    vecs[2] = mk(0,1,0,0, 19'h0,     19'h456,   8'h77, 1,0,0,1,1, 19'h456,   8'h77);
    vecs[3] = mk(1,1,0,0, 19'h111,   19'h222,   8'h33, 1,0,0,1,1, 19'h111,   8'h00);
    vecs[4] = mk(0,1,1,1, 19'h0,     19'h7FFFF, 8'h5A, 1,1,1,1,1, 19'h7FFFF, 8'h5A);
    vecs[5] = mk(1,1,1,0, 19'h10,    19'h20,    8'hFF, 1,0,0,1,1, 19'h10,    8'h00);
    vecs[6] = mk(1,0,0,1, 19'h2AAAA, 19'h0,    8'hCC, 1,0,0,0,1, 19'h2AAAA, 8'h00);

    // Reset state with requests pending
    rst_core_n = 0;
    idle_inputs();
    d_rd = 1; h_req = 1;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_h_ack", h_ack, 0);
    chk("rst_d_busy", d_busy, 1);
    chk("rst_d_vld", d_vld, 0);
    chk("rst_h_rvld", h_rvld, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_h_rdata", h_rdata, 0);
    do_reset();

    // Single-cycle grant vectors from an empty FIFO and clear starvation counter
    for (int i = 0; i < 7; i++) begin
      d_rd = vecs[i].d_rd; h_req = vecs[i].h_req; h_we = vecs[i].h_we;
      mem_ready = vecs[i].rdy; d_addr = vecs[i].da; h_addr = vecs[i].ha; h_wdata = vecs[i].hw;
      @(negedge clk_core);
      chk($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_req);
      chk($sformatf("v%0d_h_ack", i), h_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_d_busy", i), d_busy, vecs[i].e_busy);
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wd);
      end
      next_cycle();
    end
    do_reset();

    // Contention: 8 display grants then one host grant, repeating
    auto_en = 1; d_rd = 1; h_req = 1; h_we = 0; mem_ready = 1;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk_core);
      chk($sformatf("cont_h_ack_c%0d", c), h_ack, ((c % 9) == 8) ? 1 : 0);
      chk($sformatf("cont_d_busy_c%0d", c), d_busy, ((c % 9) == 8) ? 1 : 0);
      next_cycle();
    end
    d_rd = 0; h_req = 0; auto_en = 0;
    next_cycle();
    @(negedge clk_core);
    chk("cont_err", err_orphan, 0);
    do_reset();

    // Return routing: display read then host read, returns routed by tag
    d_rd = 1; d_addr = 19'h10;
    @(negedge clk_core);
    chk("route_d_addr", mem_addr, 19'h10);
    chk("route_d_busy", d_busy, 0);
    next_cycle();
    d_rd = 0; h_req = 1; h_we = 0; h_addr = 19'h20;
    @(negedge clk_core);
    chk("route_h_addr", mem_addr, 19'h20);
    chk("route_h_ack", h_ack, 1);
    next_cycle();
    h_req = 0; man_rvld = 1; mem_rdata = 8'hA5;
    @(negedge clk_core);
    chk("route_d_vld_early", d_vld, 0);
    next_cycle();
    mem_rdata = 8'h3C;
    @(negedge clk_core);
    chk("route_d_vld", d_vld, 1);
    chk("route_d_data", d_data, 8'hA5);
    chk("route_h_rvld_early", h_rvld, 0);
    next_cycle();
    man_rvld = 0; mem_rdata = 8'h00;
    @(negedge clk_core);
    chk("route_h_rvld", h_rvld, 1);
    chk("route_h_rdata", h_rdata, 8'h3C);
    chk("route_d_vld_pulse", d_vld, 0);
    chk("route_d_data_hold", d_data, 8'hA5);
    next_cycle();
    @(negedge clk_core);
    chk("route_h_rvld_pulse", h_rvld, 0);
    chk("route_h_rdata_hold", h_rdata, 8'h3C);
    do_reset();

    // FIFO full: four outstanding display reads block further reads but not writes
    d_rd = 1;
    for (int i = 0; i < 4; i++) begin
      d_addr = 19'(i);
      @(negedge clk_core);
      chk($sformatf("full_fill%0d_busy", i), d_busy, 0);
      next_cycle();
    end
    @(negedge clk_core);
    chk("full_d_busy", d_busy, 1);
    chk("full_mem_req", mem_req, 0);
    next_cycle();
    d_rd = 0; h_req = 1; h_we = 0;
    @(negedge clk_core);
    chk("full_hrd_mem_req", mem_req, 0);
    chk("full_hrd_ack", h_ack, 0);
    next_cycle();
    h_we = 1; h_addr = 19'h55; h_wdata = 8'hE7; d_rd = 1;
    @(negedge clk_core);
    chk("full_hwr_ack", h_ack, 1);
    chk("full_hwr_we", mem_we, 1);
    chk("full_hwr_wdata", mem_wdata, 8'hE7);
    chk("full_hwr_d_busy", d_busy, 1);
    next_cycle();
    h_req = 0; h_we = 0; man_rvld = 1; mem_rdata = 8'h42;
    @(negedge clk_core);
    chk("full_pushpop_req", mem_req, 1);
    chk("full_pushpop_busy", d_busy, 0);
    next_cycle();
    man_rvld = 0;
    @(negedge clk_core);
    chk("full_after_busy", d_busy, 1);
    chk("full_after_d_vld", d_vld, 1);
    chk("full_after_d_data", d_data, 8'h42);
    do_reset();

    // Backpressure: no transfer while mem_ready is low, then exactly one
    d_rd = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_core);
      chk($sformatf("bp_busy%0d", i), d_busy, 1);
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk_core);
    chk("bp_release_busy", d_busy, 0);
    next_cycle();
    d_rd = 0; man_rvld = 1; mem_rdata = 8'h81;
    next_cycle();
    @(negedge clk_core);
    chk("bp_ret_d_vld", d_vld, 1);
    chk("bp_ret_err", err_orphan, 0);
    next_cycle();
    // Orphan: the second return finds the FIFO empty
    man_rvld = 0;
    @(negedge clk_core);
    chk("orph_d_vld", d_vld, 0);
    chk("orph_h_rvld", h_rvld, 0);
    chk("orph_err", err_orphan, 1);
    chk("orph_d_data", d_data, 8'h81);
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk_core);
    chk("orph_err_sticky", err_orphan, 1);
    next_cycle();
    rst_core_n = 0;
    #1;
    chk("orph_err_rst", err_orphan, 0);
    next_cycle();
    rst_core_n = 1;

    // Reset mid-operation with three reads outstanding
    idle_inputs();
    d_rd = 1;
    for (int i = 0; i < 4; i++) next_cycle();
    d_rd = 0; man_rvld = 1; mem_rdata = 8'h99;
    next_cycle();
    man_rvld = 0;
    @(negedge clk_core);
    chk("mid_d_vld_pre", d_vld, 1);
    chk("mid_d_data_pre", d_data, 8'h99);
    next_cycle();
    d_rd = 1; h_req = 1;
    #1;
    rst_core_n = 0;
    #1;
    chk("mid_rst_d_data", d_data, 0);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_d_busy", d_busy, 1);
    chk("mid_rst_h_ack", h_ack, 0);
    next_cycle();
    rst_core_n = 1;
    idle_inputs();
    man_rvld = 1; mem_rdata = 8'h11;
    next_cycle();
    man_rvld = 0;
    @(negedge clk_core);
    chk("mid_late_err", err_orphan, 1);
    chk("mid_late_d_vld", d_vld, 0);
    chk("mid_late_h_rvld", h_rvld, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
- AWIDTH, default 19, VRAM word address width.
- PWIDTH, default 8, pixel/data width.
- TAGDEPTH, default 4, maximum number of outstanding reads, power of 2.
- STARVE_MAX, default 8, maximum number of consecutive display grants while the host waits.

REQ-002 The block SHALL have the following ports (clock and reset first):
- clk_core  in  1  core clock.
- rst_core_n  in  1  reset, asynchronous, active-low.
- d_rd  in  1  display read request.
- d_addr  in  AWIDTH  display read address.
- d_busy  out  1  display request not accepted this cycle.
- d_data  out  PWIDTH  display read data.
- d_vld  out  1  display read data valid.
- h_req  in  1  host request.
- h_we  in  1  host write (1) or read (0).
- h_addr  in  AWIDTH  host address.
- h_wdata  in  PWIDTH  host write data.
- h_ack  out  1  host request accepted this cycle.
- h_rdata  out  PWIDTH  host read data.
- h_rvld  out  1  host read data valid.
- mem_req  out  1  memory command valid.
- mem_we  out  1  memory write.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  PWIDTH  memory write data.
- mem_ready  in  1  memory accepts the command when mem_req and mem_ready are both 1.
- mem_rdata  in  PWIDTH  memory read data.
- mem_rvld  in  1  read data valid; reads return in issue order.
- err_orphan  out  1  sticky flag: mem_rvld arrived with no outstanding read.

Function
REQ-003 The grant SHALL be combinational each cycle from the requests, mem_ready, the tag FIFO fill level and the starvation counter.
REQ-004 A read request (display, or host with h_we=0) SHALL be eligible only when the tag FIFO is not full; a host write SHALL be eligible regardless of the FIFO.
REQ-005 The display SHALL win when both requesters are eligible, unless the starvation counter equals STARVE_MAX, in which case the host SHALL win.
REQ-006 mem_req SHALL be 1 whenever either requester is eligible, with mem_we, mem_addr and mem_wdata driven from the winning requester.
REQ-007 mem_wdata SHALL be 0 for display grants.
REQ-008 A transfer occurs when mem_req and mem_ready are both 1.
REQ-009 h_ack SHALL be 1 only in a cycle where the host transfer occurs.
REQ-010 d_busy SHALL equal NOT(d_rd AND display wins AND mem_ready).
REQ-011 The starvation counter SHALL increment (saturating at STARVE_MAX) on each display transfer while h_req=1, and SHALL clear on any host transfer or when h_req=0.
REQ-012 Each read transfer SHALL push a one-bit tag (0=display, 1=host) into a TAGDEPTH-entry FIFO; writes SHALL NOT push a tag.
REQ-013 On mem_rvld with the FIFO non-empty, the FIFO SHALL pop and the data SHALL be routed by the popped tag.
REQ-014 Routed data SHALL be registered: d_vld/d_data or h_rvld/h_rdata asserts exactly one cycle after mem_rvld, as a single-cycle pulse.
REQ-015 A push and a pop in the same cycle SHALL leave the fill level unchanged, and SHALL be allowed when the FIFO is full.
REQ-016 mem_rvld with the FIFO empty SHALL be dropped (no d_vld, no h_rvld) and SHALL set err_orphan, which stays set until reset.
REQ-017 d_data and h_rdata SHALL hold their last value when their valid is low.
REQ-018 FIFO pointers SHALL wrap modulo TAGDEPTH, with fill level kept as log2(TAGDEPTH)+1 bits.

Reset
REQ-019 Asserting rst_core_n low SHALL asynchronously clear all of the following, with release synchronous to clk_core:
- tag FIFO pointers and fill level.
- starvation counter.
- err_orphan.
- d_vld and h_rvld.
- d_data and h_rdata, set to 0.
REQ-020 During reset, mem_req and h_ack SHALL be 0 and d_busy SHALL be 1.
REQ-021 Reads in flight at reset SHALL be forgotten, and their late returns SHALL be treated per REQ-016.

Verification
REQ-022 Contention: d_rd and h_req (read) held high, mem_ready=1, STARVE_MAX=8 -> 8 display grants, then 1 host grant (h_ack pulse), repeating.
REQ-023 Return routing: display read of addr 0x10, then host read of 0x20, memory returns 0xA5 then 0x3C -> d_vld with 0xA5, then h_rvld with 0x3C, each exactly 1 cycle after its mem_rvld.
REQ-024 FIFO full: 4 display reads issued with no returns -> d_busy=1 and mem_req=0 for further reads; a host write is still issued (h_ack=1); a mem_rvld in the same cycle as a new read allows the push.
REQ-025 Backpressure: mem_ready=0 for 5 cycles with d_rd=1 -> d_busy=1 and no tag pushed; first cycle with mem_ready=1 -> exactly one transfer.
REQ-026 Orphan: mem_rvld with the FIFO empty -> no valid output and err_orphan=1 until rst_core_n goes low.
REQ-027 Reset mid-operation: rst_core_n low with 3 reads outstanding -> all outputs at reset values immediately, and returns after release set err_orphan.
